regfile_write_arbiter: RTL

Shares the single RegisterFile write port (wEn/wAddr/wData) between NReq writeback requesters, such as the ALU, load unit and a multi-cycle unit. Uses round-robin arbitration with a valid/ready handshake per requester. A registered output stage drives the RegisterFile write port one cycle after acceptance. Writes to register 0 are accepted but never issued.

---
 rtl/regfile_write_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter that shares one RegisterFile
// write port among NReq writeback requesters. Each requester uses a
// valid/ready handshake. A registered stage drives wEn/wAddr/wData one cycle
// after a write is accepted. Writes to register 0 are accepted but never issued.
// Optional feature: define REGFILE_ARB_BYPASS_EN to add read-port forwarding
// of the in-flight registered write (fwdData1/fwdData2).
module regfile_write_arbiter #(
  parameter int RegisterWidth = 32,
  parameter int NRegisters    = 32,
  parameter int NReq          = 3,
  localparam int AddrWidth    = $clog2(NRegisters),
  localparam int PtrWidth     = $clog2(NReq)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          holdWrites,
  input  logic [NReq-1:0]               reqValid,
  input  logic [NReq*AddrWidth-1:0]     reqAddr,
  input  logic [NReq*RegisterWidth-1:0] reqData,
  output logic [NReq-1:0]               reqReady,
  output logic                          wEn,
  output logic [AddrWidth-1:0]          wAddr,
  output logic [RegisterWidth-1:0]      wData,
  output logic [15:0]                   grantCount
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  input  logic [AddrWidth-1:0]          rdAddr1,
  input  logic [AddrWidth-1:0]          rdAddr2,
  input  logic [RegisterWidth-1:0]      rfData1,
  input  logic [RegisterWidth-1:0]      rfData2,
  output logic [RegisterWidth-1:0]      fwdData1,
  output logic [RegisterWidth-1:0]      fwdData2
`endif
);

  logic [PtrWidth-1:0]      rr_ptr;
  logic [PtrWidth-1:0]      grant_idx;
  logic [PtrWidth-1:0]      next_ptr;
  logic [PtrWidth-1:0]      scan_idx;
  logic [PtrWidth:0]        scan_sum;
  logic                     found;
  logic                     transfer;
  logic [AddrWidth-1:0]     sel_addr;
  logic [RegisterWidth-1:0] sel_data;

  // Round-robin search from rr_ptr upward (wrapping); grant the first valid requester
  always_comb begin
    reqReady  = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NReq; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PtrWidth+1)'(k);
      if (scan_sum >= (PtrWidth+1)'(NReq))
        scan_sum = scan_sum - (PtrWidth+1)'(NReq);
      scan_idx = scan_sum[PtrWidth-1:0];
      if (!found && reqValid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    // Reset low or a stall suppresses every grant
    if (found && !holdWrites && reset)
      reqReady[grant_idx] = 1'b1;
  end

  assign transfer = |(reqValid & reqReady);
  assign sel_addr = reqAddr[grant_idx*AddrWidth +: AddrWidth];
  assign sel_data = reqData[grant_idx*RegisterWidth +: RegisterWidth];
  assign next_ptr = (grant_idx == PtrWidth'(NReq-1)) ? '0 : grant_idx + 1'b1;

  // ---- acceptance -> registered write port ----
  // Advance the pointer and count on every transfer; issue the write only for a nonzero address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      wEn        <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      grantCount <= '0;
    end else begin
      wEn <= transfer && (sel_addr != '0);
      if (transfer) begin
        rr_ptr     <= next_ptr;
        grantCount <= grantCount + 16'd1;
        if (sel_addr != '0) begin
          wAddr <= sel_addr;
          wData <= sel_data;
        end
      end
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // Forward the pending registered write to a read port that targets the same nonzero register
  always_comb begin
    fwdData1 = rfData1;
    fwdData2 = rfData2;
    if (wEn && (wAddr == rdAddr1) && (rdAddr1 != '0)) fwdData1 = wData;
    if (wEn && (wAddr == rdAddr2) && (rdAddr2 != '0)) fwdData2 = wData;
  end
`endif

endmodule
